// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Booth/Wallace multiplier: op encodings,
// operand-extension helpers and partial-product count.
package mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    // Radix-4 Booth over a WIDTH+2 bit operand gives one digit per two bits.
    function automatic int num_pp(input int width);
        return (width + 2) / 2;
    endfunction

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    // rs2 is treated as signed only for MULH.
    function automatic logic op_b_signed(input logic [1:0] op);
        return op == MUL_OP_MULH;
    endfunction

    // Every op except MUL returns the upper half of the product.
    function automatic logic op_sel_high(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU) || (op == MUL_OP_MULHU);
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth digit: selects 0/+-A/+-2A, sign-extends to the full
// product width and shifts into place. Negation is done as one's complement
// here; the +1 comes back through neg_o as a separate row bit.
module booth_pp_gen #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 0
) (
    input  logic [2:0]         digit_i,
    input  logic [WIDTH+1:0]   a_ext_i,
    output logic [2*WIDTH-1:0] pp_o,
    output logic               neg_o
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH+2:0] mag;
    logic [PW-1:0]    mag_se;
    logic             neg;

    // Decode the digit {b[2i+1], b[2i], b[2i-1]} and build the shifted row.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        unique case (digit_i)
            3'b001, 3'b010: mag = {a_ext_i[WIDTH+1], a_ext_i};
            3'b011:         mag = {a_ext_i, 1'b0};
            3'b100: begin
                mag = {a_ext_i, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {a_ext_i[WIDTH+1], a_ext_i};
                neg = 1'b1;
            end
            default: ;
        endcase
        mag_se = {{(PW - WIDTH - 3){mag[WIDTH+2]}}, mag};
        pp_o   = (neg ? ~mag_se : mag_se) << SHIFT;
        neg_o  = neg;
    end

endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// Three-stage RISC-V multiplier: S1 Booth partial products, S2 3:2 CSA
// reduction to two rows, S3 carry-propagate add and high/low select.
// Valid/ready elastic pipeline with tag passthrough and flush.
module booth_wallace_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW        = 2 * WIDTH;
    localparam int NUM_PP    = num_pp(WIDTH);
    localparam int NUM_ROWS  = NUM_PP + 1;             // partial products plus the neg-bit row
    localparam int NUM_CSA   = NUM_ROWS - 2;           // each 3:2 cell removes one row
    localparam int TREE_ROWS = NUM_ROWS + 2 * NUM_CSA;

    function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] a, b, c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] a, b, c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic ld1, ld2, ld3, accept;

    logic [PW-1:0]    pp_s1 [NUM_PP];
    logic [NUM_PP-1:0] neg_s1;
    logic [PW-1:0]    pp1_q [NUM_PP];
    logic [NUM_PP-1:0] neg1_q;
    logic [1:0]       op1_q, op2_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

    logic [PW-1:0]    neg_row;
    logic [PW-1:0]    rows [TREE_ROWS];
    logic [PW-1:0]    sum2_q, carry2_q;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] res3_q;

    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+2:0] b_pad;

    // A stage may load when it is empty or its contents move on this edge.
    assign ld3      = !v3_q || out_ready;
    assign ld2      = !v2_q || ld3;
    assign ld1      = !v1_q || ld2;
    assign in_ready = ld1 && !flush;
    assign accept   = in_valid && in_ready;

    assign out_valid  = v3_q;
    assign out_result = res3_q;
    assign out_tag    = tag3_q;

    assign a_ext = {{2{op_a_signed(in_op) & in_a[WIDTH-1]}}, in_a};
    assign b_pad = {{2{op_b_signed(in_op) & in_b[WIDTH-1]}}, in_b, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PP; gi++) begin : g_pp
            booth_pp_gen #(
                .WIDTH (WIDTH),
                .SHIFT (2 * gi)
            ) u_pp (
                .digit_i (b_pad[2*gi+2 -: 3]),
                .a_ext_i (a_ext),
                .pp_o    (pp_s1[gi]),
                .neg_o   (neg_s1[gi])
            );
        end
    endgenerate

    // Valid bits shift forward whenever the downstream slot frees up.
    always_comb begin
        v3_d = ld3 ? v2_q : v3_q;
        v2_d = ld2 ? v1_q : v2_q;
        v1_d = ld1 ? accept : v1_q;
    end

    // Valid bits: reset beats flush, flush empties every stage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    // S1 data: partial products captured only on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            pp1_q  <= pp_s1;
            neg1_q <= neg_s1;
            op1_q  <= in_op;
            tag1_q <= in_tag;
        end
    end

    // CSA tree: cell k consumes rows 3k..3k+2 and appends two rows, so the
    // row list is reduced in FIFO order and depth grows with log(NUM_PP).
    always_comb begin
        neg_row = '0;
        for (int i = 0; i < NUM_PP; i++) neg_row[2*i] = neg1_q[i];
        for (int r = 0; r < TREE_ROWS; r++) rows[r] = '0;
        for (int i = 0; i < NUM_PP; i++) rows[i] = pp1_q[i];
        rows[NUM_PP] = neg_row;
        for (int k = 0; k < NUM_CSA; k++) begin
            rows[NUM_ROWS + 2*k]     = csa_sum  (rows[3*k], rows[3*k+1], rows[3*k+2]);
            rows[NUM_ROWS + 2*k + 1] = csa_carry(rows[3*k], rows[3*k+1], rows[3*k+2]);
        end
    end

    // S2 data: the two surviving rows, loaded when S1 moves forward.
    always_ff @(posedge clk) begin
        if (ld2 && v1_q) begin
            sum2_q   <= rows[TREE_ROWS-2];
            carry2_q <= rows[TREE_ROWS-1];
            op2_q    <= op1_q;
            tag2_q   <= tag1_q;
        end
    end

    assign prod = sum2_q + carry2_q;

    // S3 outputs: held while stalled, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            res3_q <= '0;
            tag3_q <= '0;
        end else if (ld3 && v2_q) begin
            res3_q <= op_sel_high(op2_q) ? prod[PW-1:WIDTH] : prod[WIDTH-1:0];
            tag3_q <= tag2_q;
        end
    end

endmodule
